dma_handshake_monitor: RTL and testbench
========================================

Name: dma_handshake_monitor

Overview:
- Synthesizable, parametrised run-time monitor for the DMA controller's DREQ/DACK/HRQ/HLDA handshake.
- Sits beside the controller on the bus interface and tracks the hold-request/grant/service sequence with a small FSM.
- Flags protocol violations as registered pulses and sticky flags.
- Keeps saturating per-channel service counters and a transfer counter, so checks and coverage also run on silicon/FPGA, not only in formal.

Parameters:
NUM_CH, 4, number of DMA channels (1..8)
MAX_LATENCY, 16, max cycles HRQ may stay high without HLDA before timeout (>=1)
CNT_W, 16, width of each saturating counter

Ports:
CLK  input  1  system clock, all logic on posedge
RESET  input  1  asynchronous, active-high reset
DREQ  input  NUM_CH  channel data requests, active high
DACK  input  NUM_CH  channel acknowledges, active high
HRQ  input  1  hold request from controller
HLDA  input  1  hold acknowledge from CPU
IOR_N  input  1  I/O read strobe, active low
IOW_N  input  1  I/O write strobe, active low
clear  input  1  synchronous clear of sticky flags and counters
state  output  2  monitor FSM state (0 IDLE, 1 WAIT, 2 GRANT, 3 ACTIVE)
err_pulse  output  4  one-cycle error pulses {timeout, hlda_no_hrq, dack_no_grant, multi_dack}
err_sticky  output  4  sticky OR of err_pulse, same bit order
dack_cnt  output  NUM_CH*CNT_W  per-channel DACK rising-edge count; channel i at [i*CNT_W +: CNT_W]
xfer_cnt  output  CNT_W  count of strobed transfer cycles

Behaviour:
- Reset (async, RESET=1): state=IDLE, err_pulse=0, err_sticky=0, all counters=0, latency counter=0, DACK history register=0. All outputs registered.
- Inputs are sampled at posedge CLK. Outputs reflect the sample one cycle later: 1-cycle latency.
- FSM transitions:
  - IDLE: HRQ=1 & HLDA=0 -> WAIT; HRQ=1 & HLDA=1 -> GRANT.
  - WAIT: HRQ=0 -> IDLE; HLDA=1 -> GRANT; otherwise stay and increment latency counter.
  - GRANT: HRQ=0 -> IDLE; any DACK -> ACTIVE.
  - ACTIVE: DACK=0 & HRQ=1 -> GRANT; DACK=0 & HRQ=0 -> IDLE; otherwise stay.
  - Any state: HLDA=0 while in GRANT/ACTIVE -> WAIT if HRQ=1, else IDLE.
- Latency counter:
  - Cleared on every entry to WAIT.
  - Saturates at MAX_LATENCY.
- Errors (each bit pulses for one cycle per offending sample):
  - multi_dack: popcount(DACK)>1.
  - dack_no_grant: DACK!=0 while HLDA=0.
  - hlda_no_hrq: HLDA=1 while HRQ=0.
  - timeout: in WAIT with latency counter == MAX_LATENCY-1 and HLDA still 0. Fires once per WAIT episode; no re-fire until WAIT is left.
  - Several errors in the same cycle all pulse together.
- err_sticky:
  - err_sticky |= err_pulse every cycle.
  - clear=1 zeroes it. If clear and a new error coincide, clear wins for old bits and the new pulse bits are still set.
- dack_cnt[i]:
  - +1 on a DACK[i] rising edge (current 1, previous sample 0).
  - Saturates at all-ones.
  - clear zeroes it; an increment in the same cycle as clear is lost.
- xfer_cnt:
  - +1 each cycle with DACK!=0 and (IOR_N=0 or IOW_N=0).
  - IOR_N=0 and IOW_N=0 together count once.
  - Saturating; cleared by clear.
- clear does not affect state or the latency counter.
- RESET mid-episode returns everything to reset values immediately. No error is reported for the aborted episode.

Test Plan:
- Normal handshake: DREQ=0001, HRQ=1 at cycle 0, HLDA=1 at cycle 3, DACK=0001 cycles 5-8 with IOR_N=0 -> state IDLE->WAIT->GRANT->ACTIVE->IDLE; dack_cnt[0]=1; xfer_cnt=4; err_sticky=0.
- Timeout, MAX_LATENCY=16: HRQ=1, HLDA=0 held 40 cycles -> err_pulse[3] single pulse 16 cycles after WAIT entry; err_sticky=1000; no second pulse.
- Multi-DACK plus no grant in one cycle: DACK=0110 with HLDA=0 -> err_pulse=0011 in one cycle; err_sticky=0011.
- HLDA without HRQ: HLDA=1, HRQ=0 for 2 cycles -> two err_pulse[2] pulses; then clear=1 -> err_sticky=0000.
- Counter saturation, CNT_W=4: toggle DACK[2] 20 times under a valid grant -> dack_cnt[2]=15 and holds; clear -> 0.
- Async reset mid-ACTIVE: assert RESET between clock edges -> all outputs 0 and state IDLE immediately; after release, the normal sequence works again.

Source files
------------

// File: rtl/dma_handshake_monitor_if.sv
// Bus bundle between the DMA controller side (master) and the handshake
// monitor (slave): observed handshake strobes in, monitor status out.
interface dma_handshake_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       DREQ;
  logic [NUM_CH-1:0]       DACK;
  logic                    HRQ;
  logic                    HLDA;
  logic                    IOR_N;
  logic                    IOW_N;
  logic                    clear;
  logic [1:0]              state;
  logic [3:0]              err_pulse;
  logic [3:0]              err_sticky;
  logic [NUM_CH*CNT_W-1:0] dack_cnt;
  logic [CNT_W-1:0]        xfer_cnt;

  modport master (
    output DREQ, DACK, HRQ, HLDA, IOR_N, IOW_N, clear,
    input  state, err_pulse, err_sticky, dack_cnt, xfer_cnt
  );

  modport slave (
    input  DREQ, DACK, HRQ, HLDA, IOR_N, IOW_N, clear,
    output state, err_pulse, err_sticky, dack_cnt, xfer_cnt
  );
endinterface

// File: rtl/dma_handshake_monitor.sv
// Run-time checker for the DMA DREQ/DACK/HRQ/HLDA handshake: tracks the hold
// sequence, flags protocol errors and keeps saturating service counters.
module dma_handshake_monitor #(
  parameter int NUM_CH      = 4,
  parameter int MAX_LATENCY = 16,
  parameter int CNT_W       = 16
) (
  input logic                    CLK,
  input logic                    RESET,
  dma_handshake_monitor_if.slave bus
);
  localparam int LAT_W = $clog2(MAX_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LATENCY);
  localparam logic [LAT_W-1:0] LAT_TRIP = LAT_W'(MAX_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_GRANT  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t            state_reg;
  logic [LAT_W-1:0]  lat_reg;
  logic [NUM_CH-1:0] dack_prev_reg;
  logic [3:0]        err_pulse_reg;
  logic [3:0]        err_sticky_reg;
  logic [3:0]        err_pulse_next;
  logic [CNT_W-1:0]  dack_cnt_reg [NUM_CH];
  logic [CNT_W-1:0]  xfer_cnt_reg;

  logic any_dack;
  logic multi_dack;
  logic xfer_hit;
  logic timeout_hit;

  assign any_dack    = |bus.DACK;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_dack  = (bus.DACK & (bus.DACK - NUM_CH'(1))) != '0;
  assign xfer_hit    = any_dack & (~bus.IOR_N | ~bus.IOW_N);
  // The latency counter saturates past the trip value, so this fires once per WAIT stay.
  assign timeout_hit = (state_reg == ST_WAIT) && (lat_reg == LAT_TRIP) && !bus.HLDA;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      lat_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.HRQ && !bus.HLDA) begin
            state_reg <= ST_WAIT;
            lat_reg   <= '0;
          end else if (bus.HRQ) begin
            state_reg <= ST_GRANT;
          end
        end
        ST_WAIT: begin
          if (!bus.HRQ) begin
            state_reg <= ST_IDLE;
          end else if (bus.HLDA) begin
            state_reg <= ST_GRANT;
          end else if (lat_reg != LAT_MAX) begin
            lat_reg <= lat_reg + LAT_W'(1);
          end
        end
        ST_GRANT: begin
          if (!bus.HLDA) begin
            state_reg <= bus.HRQ ? ST_WAIT : ST_IDLE;
            lat_reg   <= '0;
          end else if (!bus.HRQ) begin
            state_reg <= ST_IDLE;
          end else if (any_dack) begin
            state_reg <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!bus.HLDA) begin
            state_reg <= bus.HRQ ? ST_WAIT : ST_IDLE;
            lat_reg   <= '0;
          end else if (!any_dack) begin
            state_reg <= bus.HRQ ? ST_GRANT : ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    err_pulse_next    = '0;
    err_pulse_next[0] = multi_dack;
    err_pulse_next[1] = any_dack && !bus.HLDA;
    err_pulse_next[2] = bus.HLDA && !bus.HRQ;
    err_pulse_next[3] = timeout_hit;
  end

  // A clear drops old sticky bits but never masks an error seen in the same sample.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_pulse_reg  <= '0;
      err_sticky_reg <= '0;
      dack_prev_reg  <= '0;
    end else begin
      err_pulse_reg  <= err_pulse_next;
      err_sticky_reg <= (bus.clear ? 4'b0000 : err_sticky_reg) | err_pulse_next;
      dack_prev_reg  <= bus.DACK;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_dack_cnt
      logic dack_rise;
      assign dack_rise = bus.DACK[gi] & ~dack_prev_reg[gi];

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          dack_cnt_reg[gi] <= '0;
        end else if (bus.clear) begin
          dack_cnt_reg[gi] <= '0;
        end else if (dack_rise && dack_cnt_reg[gi] != CNT_SAT) begin
          dack_cnt_reg[gi] <= dack_cnt_reg[gi] + CNT_W'(1);
        end
      end

      assign bus.dack_cnt[gi*CNT_W +: CNT_W] = dack_cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      xfer_cnt_reg <= '0;
    end else if (bus.clear) begin
      xfer_cnt_reg <= '0;
    end else if (xfer_hit && xfer_cnt_reg != CNT_SAT) begin
      xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.state      = state_reg;
  assign bus.err_pulse  = err_pulse_reg;
  assign bus.err_sticky = err_sticky_reg;
  assign bus.xfer_cnt   = xfer_cnt_reg;
endmodule

// File: tb/tb_dma_handshake_monitor.sv
// Bench for dma_handshake_monitor: directed vector table, multi-cycle corner
// sequences and a randomized run against a cycle-level reference model.
module tb_dma_handshake_monitor;
  localparam int NCH  = 4;
  localparam int MLAT = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic CLK;
  logic RESET;

  dma_handshake_monitor_if #(.NUM_CH(NCH), .CNT_W(CW)) bus();

  dma_handshake_monitor #(.NUM_CH(NCH), .MAX_LATENCY(MLAT), .CNT_W(CW)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       hrq;
    logic       hlda;
    logic [3:0] dack;
    logic       ior_n;
    logic       clr;
    logic [1:0] st;
    logic [3:0] pulse;
    logic [3:0] sticky;
    logic [3:0] xfer;
    logic [3:0] cnt0;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic hrq, input logic hlda, input logic [3:0] dack,
                              input logic ior_n, input logic clr, input logic [1:0] st,
                              input logic [3:0] pulse, input logic [3:0] sticky,
                              input logic [3:0] xfer, input logic [3:0] cnt0);
    vec_t v;
    v.hrq = hrq; v.hlda = hlda; v.dack = dack; v.ior_n = ior_n; v.clr = clr;
    v.st = st; v.pulse = pulse; v.sticky = sticky; v.xfer = xfer; v.cnt0 = cnt0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hrq, input logic hlda, input logic [3:0] dack,
                       input logic ior_n, input logic iow_n, input logic clr);
    bus.HRQ   = hrq;
    bus.HLDA  = hlda;
    bus.DACK  = dack;
    bus.DREQ  = dack;
    bus.IOR_N = ior_n;
    bus.IOW_N = iow_n;
    bus.clear = clr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] cnt_of(input int ch);
    logic [NCH*CW-1:0] flat;
    flat = bus.dack_cnt;
    return flat[ch*CW +: CW];
  endfunction

  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(tbl[i].hrq, tbl[i].hlda, tbl[i].dack, tbl[i].ior_n, 1'b1, tbl[i].clr);
      tick();
      $display("vec %0d: hrq=%b hlda=%b dreq=%b dack=%b clr=%b -> state=%0d pulse=%b sticky=%b xfer=%0d cnt0=%0d",
               i, bus.HRQ, bus.HLDA, bus.DREQ, bus.DACK, bus.clear, bus.state,
               bus.err_pulse, bus.err_sticky, bus.xfer_cnt, cnt_of(0));
      check($sformatf("tbl%0d.state", i),  64'(bus.state),      64'(tbl[i].st));
      check($sformatf("tbl%0d.pulse", i),  64'(bus.err_pulse),  64'(tbl[i].pulse));
      check($sformatf("tbl%0d.sticky", i), 64'(bus.err_sticky), 64'(tbl[i].sticky));
      check($sformatf("tbl%0d.xfer", i),   64'(bus.xfer_cnt),   64'(tbl[i].xfer));
      check($sformatf("tbl%0d.cnt0", i),   64'(cnt_of(0)),      64'(tbl[i].cnt0));
    end
  endtask

  // Reference model: 0 IDLE, 1 WAIT, 2 GRANT, 3 ACTIVE; wait_age counts samples spent in WAIT.
  int         m_st;
  int         m_age;
  logic [3:0] m_prev;
  logic [3:0] m_pulse;
  logic [3:0] m_sticky;
  int         m_cnt [NCH];
  int         m_xfer;

  task automatic model_reset();
    m_st = 0; m_age = 0; m_prev = '0; m_pulse = '0; m_sticky = '0; m_xfer = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input logic hrq, input logic hlda, input logic [3:0] dack,
                            input logic ior_n, input logic iow_n, input logic clr);
    int pc;
    int nst;
    pc = $countones(dack);
    m_pulse[0] = (pc > 1);
    m_pulse[1] = (pc > 0) && !hlda;
    m_pulse[2] = hlda && !hrq;
    m_pulse[3] = (m_st == 1) && (m_age == MLAT - 1) && !hlda;
    if ((m_st >= 2) && !hlda)   nst = hrq ? 1 : 0;
    else if (m_st <= 1)         nst = !hrq ? 0 : (hlda ? 2 : 1);
    else if (m_st == 2)         nst = !hrq ? 0 : (pc > 0 ? 3 : 2);
    else                        nst = (pc > 0) ? 3 : (hrq ? 2 : 0);
    if (nst == 1 && m_st != 1)  m_age = 0;
    else if (nst == 1)          m_age = (m_age + 1 > MLAT) ? MLAT : m_age + 1;
    m_st = nst;
    m_sticky = (clr ? 4'b0000 : m_sticky) | m_pulse;
    for (int i = 0; i < NCH; i++) begin
      if (clr) m_cnt[i] = 0;
      else if (dack[i] && !m_prev[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
    end
    if (clr) m_xfer = 0;
    else if (pc > 0 && (!ior_n || !iow_n) && m_xfer < CMAX) m_xfer = m_xfer + 1;
    m_prev = dack;
  endtask

  initial begin
    int to_cnt;
    int to_at;
    int p_hlda;
    logic [29:0] exp_v;
    logic [29:0] act_v;
    logic r_hrq, r_hlda, r_ior, r_iow, r_clr;
    logic [3:0] r_dack;

    //           hrq hlda dack  ior clr  st   pulse  sticky xfer cnt0
    tbl[0]  = mk(1, 0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h0, 4'd0, 4'd0);
    tbl[1]  = mk(1, 0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h0, 4'd0, 4'd0);
    tbl[2]  = mk(1, 0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h0, 4'd0, 4'd0);
    tbl[3]  = mk(1, 1, 4'h0, 1, 0, 2'd2, 4'h0, 4'h0, 4'd0, 4'd0);
    tbl[4]  = mk(1, 1, 4'h0, 1, 0, 2'd2, 4'h0, 4'h0, 4'd0, 4'd0);
    tbl[5]  = mk(1, 1, 4'h1, 0, 0, 2'd3, 4'h0, 4'h0, 4'd1, 4'd1);
    tbl[6]  = mk(1, 1, 4'h1, 0, 0, 2'd3, 4'h0, 4'h0, 4'd2, 4'd1);
    tbl[7]  = mk(1, 1, 4'h1, 0, 0, 2'd3, 4'h0, 4'h0, 4'd3, 4'd1);
    tbl[8]  = mk(1, 1, 4'h1, 0, 0, 2'd3, 4'h0, 4'h0, 4'd4, 4'd1);
    tbl[9]  = mk(0, 0, 4'h0, 1, 0, 2'd0, 4'h0, 4'h0, 4'd4, 4'd1);
    tbl[10] = mk(0, 0, 4'h6, 1, 0, 2'd0, 4'h3, 4'h3, 4'd4, 4'd1);
    tbl[11] = mk(0, 1, 4'h0, 1, 0, 2'd0, 4'h4, 4'h7, 4'd4, 4'd1);
    tbl[12] = mk(0, 1, 4'h0, 1, 0, 2'd0, 4'h4, 4'h7, 4'd4, 4'd1);
    tbl[13] = mk(0, 0, 4'h0, 1, 1, 2'd0, 4'h0, 4'h0, 4'd0, 4'd0);

    RESET = 1'b1;
    drive(0, 0, 4'h0, 1, 1, 0);
    tick();
    tick();
    check("reset.state",  64'(bus.state),      64'd0);
    check("reset.pulse",  64'(bus.err_pulse),  64'd0);
    check("reset.sticky", 64'(bus.err_sticky), 64'd0);
    check("reset.cnts",   64'(bus.dack_cnt),   64'd0);
    check("reset.xfer",   64'(bus.xfer_cnt),   64'd0);
    RESET = 1'b0;

    run_table(0, 13);

    // Timeout: HRQ without HLDA for 40 cycles, exactly one pulse 16 cycles after WAIT entry.
    drive(1, 0, 4'h0, 1, 1, 0);
    to_cnt = 0;
    to_at  = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.err_pulse[3]) begin
        to_cnt++;
        to_at = k;
      end
    end
    $display("timeout: pulses=%0d at=%0d sticky=%b state=%0d", to_cnt, to_at, bus.err_sticky, bus.state);
    check("timeout.count",  64'(to_cnt),         64'd1);
    check("timeout.cycle",  64'(to_at),          64'd16);
    check("timeout.sticky", 64'(bus.err_sticky), 64'h8);
    check("timeout.state",  64'(bus.state),      64'd1);
    drive(0, 0, 4'h0, 1, 1, 0);
    tick();
    drive(0, 0, 4'h0, 1, 1, 1);
    tick();
    check("timeout.clear", 64'(bus.err_sticky), 64'h0);

    // Saturation: 20 rising edges on DACK[2] under a grant, 4-bit counter stops at 15.
    drive(1, 1, 4'h0, 1, 1, 0);
    tick();
    check("sat.grant", 64'(bus.state), 64'd2);
    for (int r = 0; r < 20; r++) begin
      drive(1, 1, 4'h4, 1, 1, 0);
      tick();
      if (r == 14) check("sat.reach15", 64'(cnt_of(2)), 64'd15);
      drive(1, 1, 4'h0, 1, 1, 0);
      tick();
    end
    $display("saturation: cnt2=%0d sticky=%b xfer=%0d", cnt_of(2), bus.err_sticky, bus.xfer_cnt);
    check("sat.hold",   64'(cnt_of(2)),      64'd15);
    check("sat.sticky", 64'(bus.err_sticky), 64'h0);
    check("sat.xfer",   64'(bus.xfer_cnt),   64'd0);
    drive(1, 1, 4'h0, 1, 1, 1);
    tick();
    check("sat.clear", 64'(cnt_of(2)), 64'd0);

    // Asynchronous reset between edges while ACTIVE.
    drive(1, 1, 4'h1, 0, 1, 0);
    tick();
    check("areset.pre_state", 64'(bus.state),    64'd3);
    check("areset.pre_xfer",  64'(bus.xfer_cnt), 64'd1);
    #3;
    RESET = 1'b1;
    #1;
    $display("async reset: state=%0d pulse=%b sticky=%b xfer=%0d cnts=%h",
             bus.state, bus.err_pulse, bus.err_sticky, bus.xfer_cnt, bus.dack_cnt);
    check("areset.state",  64'(bus.state),      64'd0);
    check("areset.pulse",  64'(bus.err_pulse),  64'd0);
    check("areset.sticky", 64'(bus.err_sticky), 64'd0);
    check("areset.cnts",   64'(bus.dack_cnt),   64'd0);
    check("areset.xfer",   64'(bus.xfer_cnt),   64'd0);
    drive(0, 0, 4'h0, 1, 1, 0);
    tick();
    RESET = 1'b0;
    run_table(0, 9);

    // Randomized run against the reference model.
    RESET = 1'b1;
    drive(0, 0, 4'h0, 1, 1, 0);
    tick();
    RESET = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      p_hlda = ((c / 150) % 3 == 0) ? 4 : 65;
      r_hrq  = ($urandom_range(99) < 80);
      r_hlda = ($urandom_range(99) < p_hlda);
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5: r_dack = 4'h0;
        6, 7, 8:          r_dack = 4'(1 << $urandom_range(3));
        default:          r_dack = 4'($urandom_range(15));
      endcase
      r_ior = 1'($urandom_range(1));
      r_iow = 1'($urandom_range(1));
      r_clr = ($urandom_range(49) == 0);
      drive(r_hrq, r_hlda, r_dack, r_ior, r_iow, r_clr);
      @(posedge CLK);
      model_step(r_hrq, r_hlda, r_dack, r_ior, r_iow, r_clr);
      #1;
      exp_v = '0;
      exp_v[29:28] = 2'(m_st);
      exp_v[27:24] = m_pulse;
      exp_v[23:20] = m_sticky;
      exp_v[19:16] = 4'(m_xfer);
      for (int i = 0; i < NCH; i++) exp_v[i*CW +: CW] = 4'(m_cnt[i]);
      act_v = {bus.state, bus.err_pulse, bus.err_sticky, bus.xfer_cnt, bus.dack_cnt};
      check($sformatf("rand%0d", c), 64'(act_v), 64'(exp_v));
      if (c % 500 == 499)
        $display("random cycle %0d: state=%0d sticky=%b xfer=%0d cnts=%h",
                 c, bus.state, bus.err_sticky, bus.xfer_cnt, bus.dack_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
